// File: rtl/imm_pkg.sv
// Shared types and constants for the RV32I immediate encoder.
// Holds the format enum, the RUN/ERR state type, opcode constants and the range-check helper.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    // True when v is the sign-extension of v[msb:0], i.e. v[31:msb] are all equal.
    function automatic logic sext_ok(input logic [31:0] v, input int unsigned msb);
        logic [31:0] hi;
        hi = $signed(v) >>> msb;
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I field packer with immediate range check.
// The word is meaningless whenever violation is set.
module imm_pack
    import imm_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm32,
    output logic [31:0] word,
    output logic        violation
);

    always_comb begin
        word      = '0;
        violation = 1'b0;
        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                word      = {imm32[11:0], rs1, funct3, rd, opcode};
                violation = !sext_ok(imm32, 11);
            end
            FMT_S: begin
                word      = {imm32[11:5], rs2, rs1, funct3, imm32[4:0], opcode};
                violation = !sext_ok(imm32, 11);
            end
            FMT_B: begin
                word      = {imm32[12], imm32[10:5], rs2, rs1, funct3,
                             imm32[4:1], imm32[11], opcode};
                violation = !sext_ok(imm32, 12) || imm32[0];
            end
            FMT_U: begin
                word      = {imm32[31:12], rd, opcode};
                violation = |imm32[11:0];
            end
            FMT_J: begin
                word      = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], rd, opcode};
                violation = !sext_ok(imm32, 20) || imm32[0];
            end
            default: violation = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encode.sv
// Single-stage RV32I encoder: valid/ready in, one registered output word, sticky range error.
// A violating request is swallowed and parks the block in ERR until err_clr.
module imm_encode
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm32,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             range_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] enc_count
);

    state_e      state;
    logic [31:0] word;
    logic        violation;
    logic        accept;
    logic        drain;

    imm_pack u_pack (
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct7    (funct7),
        .imm32     (imm32),
        .word      (word),
        .violation (violation)
    );

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            instr     <= '0;
            range_err <= 1'b0;
            enc_count <= '0;
        end else begin
            if (drain)
                enc_count <= enc_count + 1'b1;

            // An accept on the same edge as a drain overwrites the drained word.
            if (accept && violation) begin
                state     <= ST_ERR;
                range_err <= 1'b1;
                if (drain)
                    out_valid <= 1'b0;
            end else if (accept) begin
                instr     <= word;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end

            if (state == ST_ERR && err_clr) begin
                state     <= ST_RUN;
                range_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_encode.sv
// Bench for imm_encode: directed encoding/error/stall/reset cases, then randomized traffic
// against a spec-level model (signed range arithmetic, one-entry output queue, immediate decoder).
module tb_imm_encode;
    import imm_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid, in_ready;
    logic [2:0]    fmt;
    logic [6:0]    opcode, funct7;
    logic [4:0]    rd, rs1, rs2;
    logic [2:0]    funct3;
    logic [31:0]   imm32;
    logic          out_valid, out_ready;
    logic [31:0]   instr;
    logic          range_err, err_clr;
    logic [CW-1:0] enc_count;

    imm_encode #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
        .rs2(rs2), .funct7(funct7), .imm32(imm32), .out_valid(out_valid),
        .out_ready(out_ready), .instr(instr), .range_err(range_err),
        .err_clr(err_clr), .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_pack(input logic [2:0] f, input logic [6:0] op,
        input logic [4:0] d, input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
        input logic [6:0] f7, input logic [31:0] i);
        case (f)
            FMT_R:   return {f7, s2, s1, f3, d, op};
            FMT_I:   return {i[11:0], s1, f3, d, op};
            FMT_S:   return {i[11:5], s2, s1, f3, i[4:0], op};
            FMT_B:   return {i[12], i[10:5], s2, s1, f3, i[4:1], i[11], op};
            FMT_U:   return {i[31:12], d, op};
            FMT_J:   return {i[20], i[10:1], i[11], i[19:12], d, op};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [2:0] f, input logic [31:0] i);
        int s;
        s = $signed(i);
        case (f)
            FMT_R:        return 1'b1;
            FMT_I, FMT_S: return (s >= -2048) && (s <= 2047);
            FMT_B:        return (s >= -4096) && (s <= 4095) && !i[0];
            FMT_U:        return i[11:0] == 12'h0;
            FMT_J:        return (s >= -(1 << 20)) && (s < (1 << 20)) && !i[0];
            default:      return 1'b0;
        endcase
    endfunction

    // Immediate extractor, as an instruction decoder would see it.
    function automatic logic [31:0] ref_imm(input logic [2:0] f, input logic [31:0] w);
        case (f)
            FMT_I:   return {{20{w[31]}}, w[31:20]};
            FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_U:   return {w[31:12], 12'h0};
            FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] gen_imm(input logic [2:0] f);
        int lo, hi, step, pick;
        int unsigned r;
        r    = $urandom_range(0, 9);
        step = (f == FMT_B || f == FMT_J) ? 2 : 1;
        case (f)
            FMT_B:   begin lo = -4096;     hi = 4094;          end
            FMT_J:   begin lo = -(1 << 20); hi = (1 << 20) - 2; end
            default: begin lo = -2048;     hi = 2047;          end
        endcase
        if (f == FMT_U)
            return (r < 6) ? ($urandom & 32'hFFFFF000) : ($urandom | (32'h1 << $urandom_range(0, 11)));
        if (r < 5)
            return 32'(lo + step * int'($urandom_range(0, unsigned'((hi - lo) / step))));
        if (r < 8) begin
            pick = int'($urandom_range(0, 4));
            case (pick)
                0:       return 32'(lo);
                1:       return 32'(hi);
                2:       return 32'(lo - step);
                3:       return 32'(hi + step);
                default: return 32'(lo + 1);
            endcase
        end
        return $urandom;
    endfunction

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
        input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
        input logic [6:0] f7, input logic [31:0] i);
        fmt = f; opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm32 = i;
        in_valid = 1'b1;
    endtask

    logic [31:0]   q_word[$];
    logic [2:0]    q_fmt[$];
    logic [31:0]   q_imm[$];
    bit            merr = 1'b0;
    logic [CW-1:0] mcnt = '0;

    initial begin
        logic [31:0] wa, wb;
        bit          exp_rdy, acc;
        in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        set_req(FMT_R, 7'h0, 5'h0, 3'h0, 5'h0, 5'h0, 7'h0, 32'h0);
        in_valid = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_err", {31'h0, range_err}, 32'h0);
        chk("rst_cnt", {28'h0, enc_count}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Known encodings, back-to-back with the output always drained.
        out_ready = 1'b1;
        set_req(FMT_I, OP_LOAD, 5'd1, 3'd2, 5'd2, 5'd0, 7'd0, 32'hFFFFFFEC);
        @(negedge clk);
        chk("i_valid", {31'h0, out_valid}, 32'h1);
        chk("i_word", instr, 32'hFEC12083);
        set_req(FMT_S, OP_STORE, 5'd0, 3'd2, 5'd4, 5'd3, 7'd0, 32'h000000C8);
        @(negedge clk);
        chk("s_word", instr, 32'h0C322423);
        chk("s_imm", ref_imm(FMT_S, instr), 32'h000000C8);
        set_req(FMT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000800);
        @(negedge clk);
        chk("j_word", instr, 32'h001000EF);
        set_req(FMT_U, OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
        @(negedge clk);
        in_valid = 1'b0;
        chk("u_word", instr, 32'h123452B7);
        @(negedge clk);
        chk("drain_valid", {31'h0, out_valid}, 32'h0);
        chk("drain_cnt", {28'h0, enc_count}, 32'd4);

        // Out-of-range I immediate, then clear.
        set_req(FMT_I, OP_OPIMM, 5'd1, 3'd0, 5'd1, 5'd0, 7'd0, 32'h00000800);
        @(negedge clk);
        in_valid = 1'b0;
        chk("err_valid", {31'h0, out_valid}, 32'h0);
        chk("err_flag", {31'h0, range_err}, 32'h1);
        chk("err_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        chk("err_hold", {31'h0, range_err}, 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_flag", {31'h0, range_err}, 32'h0);
        chk("clr_ready", {31'h0, in_ready}, 32'h1);

        // Stall with two back-to-back requests, from a fresh reset.
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b0;
        wa = ref_pack(FMT_R, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'h0);
        wb = ref_pack(FMT_I, OP_OPIMM, 5'd4, 3'd0, 5'd4, 5'd0, 7'h0, 32'h5);
        set_req(FMT_R, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'hDEADBEEF);
        @(negedge clk);
        set_req(FMT_I, OP_OPIMM, 5'd4, 3'd0, 5'd4, 5'd0, 7'h0, 32'h5);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_word", instr, wa);
            chk("stall_ready", {31'h0, in_ready}, 32'h0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rel_word", instr, wb);
        chk("rel_valid", {31'h0, out_valid}, 32'h1);
        @(negedge clk);
        chk("rel_done", {31'h0, out_valid}, 32'h0);
        chk("rel_cnt", {28'h0, enc_count}, 32'd2);

        // Reset asserted while a word is stalled.
        out_ready = 1'b0;
        set_req(FMT_R, 7'h33, 5'd7, 3'd1, 5'd2, 5'd3, 7'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_valid", {31'h0, out_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_err", {31'h0, range_err}, 32'h0);
        chk("mid_rst_cnt", {28'h0, enc_count}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Randomized traffic against the model.
        repeat (3000) begin
            chk("r_valid", {31'h0, out_valid}, {31'h0, q_word.size() != 0});
            if (q_word.size() != 0) chk("r_instr", instr, q_word[0]);
            chk("r_err", {31'h0, range_err}, {31'h0, merr});
            chk("r_cnt", {28'h0, enc_count}, {28'h0, mcnt});

            fmt = ($urandom_range(0, 15) < 14) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            opcode = 7'($urandom); rd = 5'($urandom); funct3 = 3'($urandom);
            rs1 = 5'($urandom); rs2 = 5'($urandom); funct7 = 7'($urandom);
            imm32 = gen_imm(fmt);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            err_clr   = $urandom_range(0, 7) == 0;
            #1;
            exp_rdy = !merr && (q_word.size() == 0 || out_ready);
            chk("r_ready", {31'h0, in_ready}, {31'h0, exp_rdy});

            acc = in_valid && exp_rdy;
            if (q_word.size() != 0 && out_ready) begin
                if (q_fmt[0] != FMT_R) chk("r_roundtrip", ref_imm(q_fmt[0], instr), q_imm[0]);
                void'(q_word.pop_front()); void'(q_fmt.pop_front()); void'(q_imm.pop_front());
                mcnt = mcnt + 1'b1;
            end
            if (merr && err_clr) begin
                merr = 1'b0;
            end else if (acc) begin
                if (ref_legal(fmt, imm32)) begin
                    q_word.push_back(ref_pack(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm32));
                    q_fmt.push_back(fmt);
                    q_imm.push_back(imm32);
                end else begin
                    merr = 1'b1;
                end
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
